// File: rtl/branch_resolve_predict_pkg.sv
// Shared constants for branch_resolve_predict: condition codes,
// ALU flag bit positions and 2-bit counter states.
package branch_resolve_predict_pkg;

    localparam logic [3:0] COND_NONE = 4'd0;
    localparam logic [3:0] COND_BEQZ = 4'd1;
    localparam logic [3:0] COND_BNEZ = 4'd2;
    localparam logic [3:0] COND_BLTZ = 4'd3;
    localparam logic [3:0] COND_BGEZ = 4'd4;
    localparam logic [3:0] COND_JUMP = 4'd5;
    localparam logic [3:0] COND_SEQ  = 4'd6;
    localparam logic [3:0] COND_SLT  = 4'd7;
    localparam logic [3:0] COND_SLE  = 4'd8;
    localparam logic [3:0] COND_SCO  = 4'd9;

    localparam int FLAG_SF = 3;
    localparam int FLAG_ZF = 2;
    localparam int FLAG_OF = 1;
    localparam int FLAG_CF = 0;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    function automatic logic is_cond_branch(input logic [3:0] c);
        return (c >= COND_BEQZ) && (c <= COND_BGEZ);
    endfunction

endpackage

// File: rtl/branch_resolve_predict_sat_counter2.sv
// sat_counter2: one 2-bit saturating direction counter.
// inc has priority over dec; both saturate at the ends.
module sat_counter2
    import branch_resolve_predict_pkg::*;
#(
    parameter logic [1:0] INIT = CNT_WNT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    output logic [1:0] cnt
);

    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != CNT_ST)) begin
            cnt_d = cnt_q + 2'd1;
        end else if (dec && (cnt_q != CNT_SNT)) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= INIT;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/branch_resolve_predict.sv
// Branch resolve + 2-bit direction predictor with registered result.
// Optional BRANCH_STATS_EN adds branch / mispredict event counters.
module branch_resolve_predict
    import branch_resolve_predict_pkg::*;
#(
    parameter int         PC_W     = 16,
    parameter int         IDX_W    = 4,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] pf_pc,
    output logic            pf_pred_taken,
    input  logic            ex_valid,
    input  logic [PC_W-1:0] ex_pc,
    input  logic [3:0]      ex_cond,
    input  logic [3:0]      ex_flags,
    input  logic            ex_pred_taken,
    input  logic            stall,
`ifdef BRANCH_STATS_EN
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts,
`endif
    output logic            res_valid,
    output logic            res_taken,
    output logic            res_setrd,
    output logic            res_mispredict
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [1:0]       cnt [ENTRIES];
    logic [IDX_W-1:0] pf_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             unused_pc_bits;

    logic sf;
    logic zf;
    logic of_f;
    logic cf;
    logic taken_c;
    logic setrd_c;
    logic mis_c;
    logic is_cond;
    logic upd;

    // Halfword-aligned PCs: bit 0 carries no index information.
    assign pf_idx = pf_pc[IDX_W:1];
    assign ex_idx = ex_pc[IDX_W:1];
    assign unused_pc_bits = ^{pf_pc, ex_pc};

    assign sf   = ex_flags[FLAG_SF];
    assign zf   = ex_flags[FLAG_ZF];
    assign of_f = ex_flags[FLAG_OF];
    assign cf   = ex_flags[FLAG_CF];

    always_comb begin
        taken_c = 1'b0;
        setrd_c = 1'b0;
        case (ex_cond)
            COND_BEQZ: taken_c = zf;
            COND_BNEZ: taken_c = ~zf;
            COND_BLTZ: taken_c = sf;
            COND_BGEZ: taken_c = ~sf;
            COND_JUMP: taken_c = 1'b1;
            COND_SEQ:  setrd_c = zf;
            COND_SLT:  setrd_c = sf ^ of_f;
            COND_SLE:  setrd_c = (sf ^ of_f) | zf;
            COND_SCO:  setrd_c = cf;
            default: begin
                taken_c = 1'b0;
                setrd_c = 1'b0;
            end
        endcase
    end

    assign is_cond = is_cond_branch(ex_cond);

    always_comb begin
        mis_c = 1'b0;
        if (is_cond) begin
            mis_c = taken_c ^ ex_pred_taken;
        end else if (ex_cond == COND_JUMP) begin
            mis_c = ~ex_pred_taken;
        end
    end

    assign upd = ex_valid & ~stall & is_cond;

    for (genvar i = 0; i < ENTRIES; i++) begin : g_tbl
        logic hit;
        assign hit = upd & (ex_idx == IDX_W'(i));
        sat_counter2 #(
            .INIT(CNT_INIT)
        ) u_cnt (
            .clk(clk),
            .rst(rst),
            .inc(hit & taken_c),
            .dec(hit & ~taken_c),
            .cnt(cnt[i])
        );
    end

    // Read is from the counter flops, so a same-cycle update is not seen.
    assign pf_pred_taken = cnt[pf_idx][1];

    logic res_valid_q, res_valid_d;
    logic res_taken_q, res_taken_d;
    logic res_setrd_q, res_setrd_d;
    logic res_mis_q,   res_mis_d;

    always_comb begin
        res_valid_d = res_valid_q;
        res_taken_d = res_taken_q;
        res_setrd_d = res_setrd_q;
        res_mis_d   = res_mis_q;
        if (!stall) begin
            res_valid_d = ex_valid;
            res_taken_d = ex_valid & taken_c;
            res_setrd_d = ex_valid & setrd_c;
            res_mis_d   = ex_valid & mis_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_taken_q <= 1'b0;
            res_setrd_q <= 1'b0;
            res_mis_q   <= 1'b0;
        end else begin
            res_valid_q <= res_valid_d;
            res_taken_q <= res_taken_d;
            res_setrd_q <= res_setrd_d;
            res_mis_q   <= res_mis_d;
        end
    end

    assign res_valid      = res_valid_q;
    assign res_taken      = res_taken_q;
    assign res_setrd      = res_setrd_q;
    assign res_mispredict = res_mis_q;

`ifdef BRANCH_STATS_EN
    logic        br_evt;
    logic [31:0] stat_br_q, stat_br_d;
    logic [31:0] stat_mp_q, stat_mp_d;

    assign br_evt = ex_valid & ~stall & (is_cond | (ex_cond == COND_JUMP));

    always_comb begin
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (br_evt) begin
            stat_br_d = stat_br_q + 32'd1;
            if (mis_c) begin
                stat_mp_d = stat_mp_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_br_q <= 32'd0;
            stat_mp_q <= 32'd0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_resolve_predict.sv
// Self-checking bench for branch_resolve_predict against a
// spec-level model (int counters per PC index, flag equations).
module tb_branch_resolve_predict;

    logic        clk;
    logic        rst;
    logic [15:0] pf_pc;
    logic        pf_pred_taken;
    logic        ex_valid;
    logic [15:0] ex_pc;
    logic [3:0]  ex_cond;
    logic [3:0]  ex_flags;
    logic        ex_pred_taken;
    logic        stall;
    logic        res_valid;
    logic        res_taken;
    logic        res_setrd;
    logic        res_mispredict;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    branch_resolve_predict #(
        .PC_W(16),
        .IDX_W(4),
        .CNT_INIT(2'b01)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pf_pc(pf_pc),
        .pf_pred_taken(pf_pred_taken),
        .ex_valid(ex_valid),
        .ex_pc(ex_pc),
        .ex_cond(ex_cond),
        .ex_flags(ex_flags),
        .ex_pred_taken(ex_pred_taken),
        .stall(stall),
`ifdef BRANCH_STATS_EN
        .stat_branches(stat_branches),
        .stat_mispredicts(stat_mispredicts),
`endif
        .res_valid(res_valid),
        .res_taken(res_taken),
        .res_setrd(res_setrd),
        .res_mispredict(res_mispredict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    int          m_cnt [16];
    logic        e_valid, e_taken, e_setrd, e_mis;
    logic [31:0] m_br, m_mp;

    function automatic logic ref_taken(input int c, input logic [3:0] f);
        case (c)
            1: return f[2];
            2: return !f[2];
            3: return f[3];
            4: return !f[3];
            5: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic ref_setrd(input int c, input logic [3:0] f);
        case (c)
            6: return f[2];
            7: return f[3] != f[1];
            8: return (f[3] != f[1]) || f[2];
            9: return f[0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic ref_mis(input int c, input logic [3:0] f,
                                     input logic p);
        if (c >= 1 && c <= 4) return ref_taken(c, f) != p;
        if (c == 5) return !p;
        return 1'b0;
    endfunction

    function automatic logic pred_of(input logic [15:0] pc);
        return m_cnt[pc[4:1]] >= 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_cnt[i] = 1;
        e_valid = 0; e_taken = 0; e_setrd = 0; e_mis = 0;
        m_br = 0; m_mp = 0;
    endtask

    // Drive one execute cycle; model advances at the clock edge.
    task automatic apply(input logic v, input int c, input logic [3:0] f,
                         input logic p, input logic [15:0] pc,
                         input logic st);
        int idx;
        ex_valid = v; ex_cond = 4'(c); ex_flags = f;
        ex_pred_taken = p; ex_pc = pc; stall = st;
        @(posedge clk);
        if (!st) begin
            e_valid = v;
            e_taken = v && ref_taken(c, f);
            e_setrd = v && ref_setrd(c, f);
            e_mis   = v && ref_mis(c, f, p);
            idx = int'(pc[4:1]);
            if (v && c >= 1 && c <= 4) begin
                if (ref_taken(c, f)) m_cnt[idx] = (m_cnt[idx] == 3) ? 3 : m_cnt[idx] + 1;
                else m_cnt[idx] = (m_cnt[idx] == 0) ? 0 : m_cnt[idx] - 1;
            end
            if (v && c >= 1 && c <= 5) begin
                m_br = m_br + 1;
                if (ref_mis(c, f, p)) m_mp = m_mp + 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pf_pc = 16'h0000; ex_valid = 0; ex_pc = 0; ex_cond = 0;
        ex_flags = 0; ex_pred_taken = 0; stall = 0;
        model_reset();
        #12;
        total++;
        if ({pf_pred_taken, res_valid, res_taken, res_setrd, res_mispredict} !== 5'b0) begin
            $display("FAIL reset: got pf/res=%b want 00000",
                     {pf_pred_taken, res_valid, res_taken, res_setrd, res_mispredict});
        end else passed++;
`ifdef BRANCH_STATS_EN
        total++;
        if (stat_branches !== 0 || stat_mispredicts !== 0) begin
            $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_branches, stat_mispredicts);
        end else passed++;
`endif
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_beqz_first();
        apply(1, 1, 4'b0100, 0, 16'h0000, 0);
        total++;
        if ({res_valid, res_taken, res_mispredict} !== 3'b111) begin
            $display("FAIL beqz_res: got v/t/m=%b want 111",
                     {res_valid, res_taken, res_mispredict});
        end else passed++;
        pf_pc = 16'h0000; #1;
        total++;
        if (pf_pred_taken !== 1'b1 || pf_pred_taken !== pred_of(pf_pc)) begin
            $display("FAIL beqz_pred: got %b want 1", pf_pred_taken);
        end else passed++;
    endtask

    task automatic test_saturate();
        pf_pc = 16'h0004;
        for (int i = 0; i < 5; i++) apply(1, 2, 4'b0000, 1, 16'h0004, 0);
        #1;
        total++;
        if (pf_pred_taken !== 1'b1 || m_cnt[2] != 3) begin
            $display("FAIL sat_hi: got pred %b want 1 (model cnt %0d want 3)",
                     pf_pred_taken, m_cnt[2]);
        end else passed++;
        total++;
        if (res_taken !== 1'b1 || res_mispredict !== 1'b0) begin
            $display("FAIL sat_res: got t/m=%b%b want 10", res_taken, res_mispredict);
        end else passed++;
        apply(1, 2, 4'b0100, 1, 16'h0004, 0);
        #1;
        total++;
        if (pf_pred_taken !== 1'b1 || m_cnt[2] != 2) begin
            $display("FAIL sat_dec: got pred %b want 1 (model cnt %0d want 2)",
                     pf_pred_taken, m_cnt[2]);
        end else passed++;
        apply(1, 2, 4'b0100, 1, 16'h0004, 0);
        #1;
        total++;
        if (pf_pred_taken !== 1'b0) begin
            $display("FAIL sat_dec2: got pred %b want 0", pf_pred_taken);
        end else passed++;
    endtask

    task automatic test_set_codes();
        pf_pc = 16'h0006;
        apply(1, 8, 4'b1010, 0, 16'h0006, 0);
        total++;
        if (res_setrd !== 1'b0 || res_taken !== 1'b0 || res_mispredict !== 1'b0) begin
            $display("FAIL sle_zf0: got s/t/m=%b%b%b want 000",
                     res_setrd, res_taken, res_mispredict);
        end else passed++;
        apply(1, 8, 4'b1110, 0, 16'h0006, 0);
        total++;
        if (res_setrd !== 1'b1) begin
            $display("FAIL sle_zf1: got setrd %b want 1", res_setrd);
        end else passed++;
        total++;
        if (pf_pred_taken !== 1'b0 || m_cnt[3] != 1) begin
            $display("FAIL sle_table: got pred %b want 0", pf_pred_taken);
        end else passed++;
    endtask

    task automatic test_stall();
        logic [3:0] prev;
        prev = {res_valid, res_taken, res_setrd, res_mispredict};
        pf_pc = 16'h0008;
        apply(1, 3, 4'b1000, 0, 16'h0008, 1);
        total++;
        if ({res_valid, res_taken, res_setrd, res_mispredict} !== prev) begin
            $display("FAIL stall_hold: got %b want %b",
                     {res_valid, res_taken, res_setrd, res_mispredict}, prev);
        end else passed++;
        total++;
        if (pf_pred_taken !== 1'b0) begin
            $display("FAIL stall_cnt: got pred %b want 0", pf_pred_taken);
        end else passed++;
        apply(1, 3, 4'b1000, 0, 16'h0008, 0);
        total++;
        if ({res_valid, res_taken, res_setrd, res_mispredict} !== 4'b1101
            || pf_pred_taken !== 1'b1) begin
            $display("FAIL stall_release: got res %b pred %b want 1101 pred 1",
                     {res_valid, res_taken, res_setrd, res_mispredict}, pf_pred_taken);
        end else passed++;
        apply(0, 3, 4'b1000, 0, 16'h0008, 0);
        total++;
        if ({res_valid, res_taken, res_setrd, res_mispredict} !== 4'b0000
            || pf_pred_taken !== 1'b1) begin
            $display("FAIL invalid_clear: got res %b pred %b want 0000 pred 1",
                     {res_valid, res_taken, res_setrd, res_mispredict}, pf_pred_taken);
        end else passed++;
    endtask

    task automatic test_random();
        logic        v, p, st;
        int          c;
        logic [3:0]  f;
        logic [15:0] pc;
        for (int n = 0; n < 400; n++) begin
            v  = ($urandom_range(3, 0) != 0);
            c  = $urandom_range(15, 0);
            f  = 4'($urandom);
            p  = 1'($urandom);
            pc = 16'($urandom_range(31, 0));
            st = ($urandom_range(7, 0) == 0);
            pf_pc = ($urandom_range(1, 0) != 0) ? pc : 16'($urandom);
            ex_valid = v; ex_cond = 4'(c); ex_flags = f;
            ex_pred_taken = p; ex_pc = pc; stall = st;
            #1;
            total++;
            if (pf_pred_taken !== pred_of(pf_pc)) begin
                $display("FAIL rnd_pred[%0d]: pc %h got %b want %b",
                         n, pf_pc, pf_pred_taken, pred_of(pf_pc));
            end else passed++;
            apply(v, c, f, p, pc, st);
            total++;
            if ({res_valid, res_taken, res_setrd, res_mispredict}
                !== {e_valid, e_taken, e_setrd, e_mis}) begin
                $display("FAIL rnd_res[%0d]: cond %0d flags %b got %b want %b",
                         n, c, f, {res_valid, res_taken, res_setrd, res_mispredict},
                         {e_valid, e_taken, e_setrd, e_mis});
            end else passed++;
`ifdef BRANCH_STATS_EN
            total++;
            if (stat_branches !== m_br || stat_mispredicts !== m_mp) begin
                $display("FAIL rnd_stats[%0d]: got %0d/%0d want %0d/%0d",
                         n, stat_branches, stat_mispredicts, m_br, m_mp);
            end else passed++;
`endif
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        pf_pc = 16'h000A;
        for (int i = 0; i < 4; i++) apply(1, 4, 4'b0000, 1, 16'h000A, 0);
        #1;
        total++;
        if (pf_pred_taken !== 1'b1) begin
            $display("FAIL pre_reset_sat: got pred %b want 1", pf_pred_taken);
        end else passed++;
        ex_valid = 1; ex_cond = 4'd4; ex_flags = 0; ex_pc = 16'h000A;
        rst = 1'b1;
        #1;
        model_reset();
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            pf_pc = 16'(i * 2);
            #1;
            if (pf_pred_taken !== 1'b0) bad++;
        end
        total++;
        if (bad != 0 || {res_valid, res_taken, res_setrd, res_mispredict} !== 4'b0) begin
            $display("FAIL mid_reset: got %0d entries predicting taken, res %b want 0 and 0000",
                     bad, {res_valid, res_taken, res_setrd, res_mispredict});
        end else passed++;
`ifdef BRANCH_STATS_EN
        total++;
        if (stat_branches !== 0 || stat_mispredicts !== 0) begin
            $display("FAIL mid_reset_stats: got %0d/%0d want 0/0",
                     stat_branches, stat_mispredicts);
        end else passed++;
`endif
        rst = 1'b0;
        @(posedge clk); #1;
        pf_pc = 16'h000A;
        apply(1, 4, 4'b0000, 0, 16'h000A, 0);
        total++;
        if (pf_pred_taken !== 1'b1 || res_mispredict !== 1'b1) begin
            $display("FAIL post_reset: got pred %b mis %b want 1 1",
                     pf_pred_taken, res_mispredict);
        end else passed++;
    endtask

    initial begin
        test_reset();
        test_beqz_first();
        test_saturate();
        test_set_codes();
        test_stall();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
